// File: rtl/jtcps2_keyseq.sv
// Purpose : captures the 20-byte CPS2 key during ROM download and replays it
//           byte by byte to the key loader, on download end or on a reload edge.
// Latency : 20*(1+2*HOLD)+1 cycles from start to key_done; no backpressure.
// Ports   : clk/rst_n; downloading, prog_addr/prog_data/prog_we (download bus);
//           reload (replay request); din/din_we (loader side); busy, key_done, key_err.
module jtcps2_keyseq #(
  parameter logic [21:0] KEY_BASE = 22'h0,
  parameter int          HOLD     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic        prog_we,
  input  logic        reload,
  output logic [7:0]  din,
  output logic        din_we,
  output logic        busy,
  output logic        key_done,
  output logic        key_err
);

  localparam int         NKEY      = 20;
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
  localparam logic [4:0] IDX_LAST  = 5'(NKEY - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      hold_q, hold_d;
  logic [4:0]      idx_q, idx_d;
  logic [NKEY-1:0] mask_q, mask_d;
  logic [7:0]      din_q, din_d;
  logic            key_done_q, key_done_d;
  logic            key_err_q, key_err_d;
  logic            dl_prev_q, rl_prev_q;
  logic [7:0]      buf_q [NKEY];

  logic [21:0]     offset;
  logic            hit, dl_rise, dl_fall, rl_rise, mask_full, active, start;

  // Subtracting the base folds both bounds into a single unsigned compare.
  assign offset    = prog_addr - KEY_BASE;
  assign hit       = prog_we & downloading & (offset < 22'(NKEY));
  assign dl_rise   = downloading & ~dl_prev_q;
  assign dl_fall   = ~downloading & dl_prev_q;
  assign rl_rise   = reload & ~rl_prev_q;
  assign mask_full = &mask_q;
  assign active    = (state_q == SETUP) || (state_q == HIGH) || (state_q == LOW);

  // State and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      idx_q      <= '0;
      mask_q     <= '0;
      din_q      <= '0;
      key_done_q <= 1'b0;
      key_err_q  <= 1'b0;
      dl_prev_q  <= 1'b0;
      rl_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      din_q      <= din_d;
      key_done_q <= key_done_d;
      key_err_q  <= key_err_d;
      dl_prev_q  <= downloading;
      rl_prev_q  <= reload;
    end
  end

  // Key storage carries no reset: its content only matters once the mask is full.
  always_ff @(posedge clk) begin
    if (hit) buf_q[offset[4:0]] <= prog_data;
  end

  // Next state: download start beats everything, then download end, then reload.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    start   = 1'b0;
    if (dl_rise) begin
      state_d = IDLE;
      hold_d  = '0;
      idx_d   = '0;
    end else if (dl_fall) begin
      start = mask_full;
    end else if (rl_rise && !downloading && !active && mask_full) begin
      start = 1'b1;
    end else begin
      case (state_q)
        SETUP: begin
          state_d = HIGH;
          hold_d  = '0;
        end
        HIGH: begin
          if (hold_q == HOLD_LAST) begin
            state_d = LOW;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        LOW: begin
          if (hold_q == HOLD_LAST) begin
            hold_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = SETUP;
            end
          end else begin
            hold_d = hold_q + 4'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (start) begin
      state_d = SETUP;
      hold_d  = '0;
      idx_d   = '0;
    end
  end

  // Outputs and datapath registers
  always_comb begin
    mask_d = dl_rise ? '0 : mask_q;
    if (hit) mask_d[offset[4:0]] = 1'b1;

    key_err_d = key_err_q;
    if (dl_rise)                   key_err_d = 1'b0;
    else if (dl_fall && !mask_full) key_err_d = 1'b1;

    key_done_d = key_done_q;
    if (dl_rise || start)       key_done_d = 1'b0;
    else if (state_d == DONE)   key_done_d = 1'b1;

    // din is loaded on entry to SETUP and then held through HIGH and LOW.
    din_d = din_q;
    if (state_d == SETUP) din_d = buf_q[idx_d];
  end

  assign din      = din_q;
  assign din_we   = (state_q == HIGH);
  assign busy     = active;
  assign key_done = key_done_q;
  assign key_err  = key_err_q;

endmodule
